// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux-select arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned SELW     = 2;
  localparam int unsigned HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] sel2onehot(input logic [SELW-1:0] s);
    return NREQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_arb4_sel_if.sv
// Request/select/handshake bundle between the arbiter and its requesters/consumer.
interface rr_arb4_sel_if;
  import rr_arb_pkg::*;

  logic [NREQ-1:0] req;
  logic            out_ready;
  logic            s1;
  logic            s0;
  logic [NREQ-1:0] gnt;
  logic            valid;
  logic            last;

  modport slave (
    input  req, out_ready,
    output s1, s0, gnt, valid, last
  );

  modport master (
    output req, out_ready,
    input  s1, s0, gnt, valid, last
  );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set request searching ptr, ptr+1, ... modulo 4.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    any  = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SELW'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter driving {s1,s0} of a 4:1 mux, with bounded bursts and valid/ready.
module rr_arb4_sel
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEF,
  parameter int unsigned CW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arb4_sel_if.slave  bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q,   sel_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [SELW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic [SELW-1:0] pick_ptr_c;
  logic [SELW-1:0] pick_idx_c;
  logic            pick_any_c;
  logic            valid_c;
  logic            beat_c;
  logic            last_c;
  logic            rel_c;

  // In GRANT the pick only matters on release, where the owner must rank last.
  always_comb begin
    pick_ptr_c = ptr_q;
    if (state_q == GRANT) begin
      pick_ptr_c = sel_q + SELW'(1);
    end
  end

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (pick_ptr_c),
    .idx (pick_idx_c),
    .any (pick_any_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_c = 1'b0;
    beat_c  = 1'b0;
    last_c  = 1'b0;
    rel_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d = GRANT;
          sel_d   = pick_idx_c;
          gnt_d   = sel2onehot(pick_idx_c);
          cnt_d   = '0;
        end
      end

      GRANT: begin
        valid_c = bus.req[sel_q];
        beat_c  = valid_c & bus.out_ready;
        last_c  = beat_c & (cnt_q == CNT_LAST);
        rel_c   = ~bus.req[sel_q] | last_c;

        if (beat_c) begin
          cnt_d = cnt_q + CW'(1);
        end

        // Release hands straight over to the next requester, or idles if none.
        if (rel_c) begin
          ptr_d = sel_q + SELW'(1);
          cnt_d = '0;
          if (pick_any_c) begin
            sel_d = pick_idx_c;
            gnt_d = sel2onehot(pick_idx_c);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_c;
  assign bus.last  = last_c;

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Bench for rr_arb4_sel: integer-level arbitration model plus pinned hand-computed cycles.
module tb_rr_arb4_sel;

  localparam int HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rr_arb4_sel_if ifc ();

  rr_arb4_sel #(.HOLD(HOLD), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Model: owner index (-1 when nobody holds the mux), beats taken, rotating pointer.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  logic m_valid, m_acc, m_last, m_rel;

  int n_pass  = 0;
  int n_total = 0;

  logic       lit_en  = 1'b0;
  logic [3:0] lit_gnt = 4'b0;
  int         lit_sel = 0;
  logic       lit_v   = 1'b0;
  logic       lit_l   = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    int res;
    res = -1;
    for (int k = 3; k >= 0; k--) begin
      if (r[(p + k) % 4]) res = (p + k) % 4;
    end
    return res;
  endfunction

  always_comb begin
    m_valid = 1'b0;
    if (m_owner >= 0) m_valid = ifc.req[m_owner[1:0]];
    m_acc  = m_valid && ifc.out_ready;
    m_last = m_acc && (m_beats == HOLD - 1);
    m_rel  = (m_owner >= 0) && (!m_valid || m_last);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_beats <= 0;
      m_ptr   <= 0;
      m_sel   <= 0;
    end else if (m_owner < 0) begin
      if (ifc.req != 4'b0) begin
        m_owner <= pick(ifc.req, m_ptr);
        m_sel   <= pick(ifc.req, m_ptr);
        m_beats <= 0;
      end
    end else if (m_rel) begin
      m_ptr   <= (m_owner + 1) % 4;
      m_beats <= 0;
      if (ifc.req != 4'b0) begin
        m_owner <= pick(ifc.req, (m_owner + 1) % 4);
        m_sel   <= pick(ifc.req, (m_owner + 1) % 4);
      end else begin
        m_owner <= -1;
      end
    end else if (m_acc) begin
      m_beats <= m_beats + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    int sel_now;
    int exp_gnt;
    sel_now = int'({ifc.s1, ifc.s0});
    if (!rst_n) begin
      chk("rst_gnt",   int'(ifc.gnt),   0);
      chk("rst_sel",   sel_now,         0);
      chk("rst_valid", int'(ifc.valid), 0);
      chk("rst_last",  int'(ifc.last),  0);
    end else begin
      exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("gnt",   int'(ifc.gnt),   exp_gnt);
      chk("sel",   sel_now,         m_sel);
      chk("valid", int'(ifc.valid), int'(m_valid));
      chk("last",  int'(ifc.last),  int'(m_last));
      if (lit_en) begin
        chk("lit_gnt",   int'(ifc.gnt),   int'(lit_gnt));
        chk("lit_sel",   sel_now,         lit_sel);
        chk("lit_valid", int'(ifc.valid), int'(lit_v));
        chk("lit_last",  int'(ifc.last),  int'(lit_l));
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #1;
    ifc.req       = r;
    ifc.out_ready = rdy;
    lit_en        = 1'b0;
  endtask

  task automatic pin(input logic [3:0] g, input int s, input logic v, input logic l);
    lit_gnt = g;
    lit_sel = s;
    lit_v   = v;
    lit_l   = l;
    lit_en  = 1'b1;
  endtask

  initial begin
    int own;
    ifc.req       = 4'b0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester: 1-cycle latency, 4 beats, re-grant without bubble
    step(4'b0100, 1'b1); pin(4'b0000, 0, 1'b0, 1'b0);
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b1);
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);

    // Stall at cnt=1 for 5 cycles, then three beats finish the burst
    repeat (5) begin
      step(4'b0100, 1'b0); pin(4'b0100, 2, 1'b1, 1'b0);
    end
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b1);

    // Asynchronous reset mid-burst at cnt=2, released before the next edge
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    #1 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    step(4'b0100, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);

    // Withdraw with nobody else requesting: idle, sel holds its value
    step(4'b0000, 1'b1); pin(4'b0100, 2, 1'b0, 1'b0);
    step(4'b1111, 1'b1); pin(4'b0000, 2, 1'b0, 1'b0);

    // Full load: pointer is at 3, so rotation runs 3,0,1,2,3
    for (int i = 0; i < 18; i++) begin
      step(4'b1111, 1'b1);
      own = (3 + i / 4) % 4;
      pin(4'((1 << own)), own, 1'b1, ((i % 4) == 3));
    end

    // Requester 3 withdraws after 2 beats with req[0] set: pointer wraps to 0
    step(4'b0001, 1'b1); pin(4'b1000, 3, 1'b0, 1'b0);
    step(4'b0001, 1'b1); pin(4'b0001, 0, 1'b1, 1'b0);

    // Pointer priority after index 1 releases: req=0011 picks 0
    step(4'b0010, 1'b1); pin(4'b0001, 0, 1'b0, 1'b0);
    step(4'b0010, 1'b1); pin(4'b0010, 1, 1'b1, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0011, 1'b1); pin(4'b0010, 1, 1'b1, 1'b1);
    step(4'b0011, 1'b1); pin(4'b0001, 0, 1'b1, 1'b0);

    // Same setup, req=0111 picks 2
    step(4'b0010, 1'b1); pin(4'b0001, 0, 1'b0, 1'b0);
    step(4'b0010, 1'b1); pin(4'b0010, 1, 1'b1, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0111, 1'b1); pin(4'b0010, 1, 1'b1, 1'b1);
    step(4'b0111, 1'b1); pin(4'b0100, 2, 1'b1, 1'b0);

    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0); pin(4'b0000, 2, 1'b0, 1'b0);
    step(4'b0000, 1'b0);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
